// File: rtl/mem_pkg.sv
// Shared constants and helpers for the memory bank controller.
//   DefDataW, DefDepth, DefDebCycles : default parameter values
//   even_parity()                    : even parity bit over a data word (zero-extended)
package mem_pkg;

  localparam int unsigned DefDataW     = 8;
  localparam int unsigned DefDepth     = 16;
  localparam int unsigned DefDebCycles = 4;

  // Widest data word the parity helper accepts; callers zero-extend into it.
  localparam int unsigned MaxDataW = 64;

  // Returns the bit that makes the total count of ones (data + bit) even.
  function automatic logic even_parity(input logic [MaxDataW-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/btn_pulse.sv
// Debounced single-pulse generator for one raw push-button.
//   clk     : system clock, rising edge
//   rst     : synchronous active-low reset
//   i_btn   : raw asynchronous button level
//   o_pulse : one-cycle registered pulse after DEB_CYCLES stable-high samples
// A held button produces one pulse; it re-arms after a single low synchronised sample.
module btn_pulse import mem_pkg::*; #(
  parameter int unsigned DEB_CYCLES = DefDebCycles
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int unsigned   CntW    = $clog2(DEB_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(DEB_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEB_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic            sync1_q, sync2_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pulse_q, pulse_d;

  // Counter saturates at CntMax, so a held button cannot pulse again until it drops.
  always_comb begin
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (!sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d   = cnt_q + CntOne;
      pulse_d = (cnt_q == CntLast);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign o_pulse = pulse_q;

endmodule

// File: rtl/mem_bank_ctrl.sv
// DEPTH x DATA_W register-file memory driven by raw board buttons and switches.
//   clk, rst   : system clock (rising edge), synchronous active-low reset
//   write_en   : raw button, write d_in at the pointer and advance it
//   save_data  : raw button, copy the current word into the save register
//   addr_inc   : raw button, advance the pointer (wraps DEPTH-1 -> 0)
//   show_reg   : level switch, 1 displays the save register, 0 displays mem[addr]
//   d_in       : data switches
//   d_out      : registered display data
//   addr_out   : current address pointer
//   full       : every address written at least once since reset
//   par_err    : sticky parity error on save
// Optional feature macro MEM_PARITY_EN: stores an even parity bit per word and checks it on
// save. Without it, par_err is tied low.
module mem_bank_ctrl import mem_pkg::*; #(
  parameter  int unsigned DATA_W     = DefDataW,
  parameter  int unsigned DEPTH      = DefDepth,
  parameter  int unsigned DEB_CYCLES = DefDebCycles,
  localparam int unsigned AW         = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_en,
  input  logic              save_data,
  input  logic              addr_inc,
  input  logic              show_reg,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  output logic [AW-1:0]     addr_out,
  output logic              full,
  output logic              par_err
);

`ifdef MEM_PARITY_EN
  localparam int unsigned WordW = DATA_W + 1;
`else
  localparam int unsigned WordW = DATA_W;
`endif

  logic wr_pulse, save_pulse, inc_pulse;

  btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_wr_btn (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (write_en),
    .o_pulse (wr_pulse)
  );

  btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_save_btn (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (save_data),
    .o_pulse (save_pulse)
  );

  btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_inc_btn (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (addr_inc),
    .o_pulse (inc_pulse)
  );

  logic [DEPTH-1:0][WordW-1:0] mem_q;
  logic [AW-1:0]               addr_q;
  logic [DATA_W-1:0]           save_q;
  logic [DEPTH-1:0]            written_q;
  logic [DATA_W-1:0]           d_out_q;

  logic [WordW-1:0]  wr_word;
  logic [WordW-1:0]  rd_word;
  logic [DATA_W-1:0] rd_data;

`ifdef MEM_PARITY_EN
  assign wr_word = {even_parity(MaxDataW'(d_in)), d_in};
`else
  assign wr_word = d_in;
`endif

  // Read side sees the pre-edge contents, so a same-cycle save captures the old word.
  assign rd_word = mem_q[addr_q];
  assign rd_data = rd_word[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q     <= '0;
      addr_q    <= '0;
      save_q    <= '0;
      written_q <= '0;
      d_out_q   <= '0;
    end else begin
      if (wr_pulse) begin
        mem_q[addr_q]     <= wr_word;
        written_q[addr_q] <= 1'b1;
      end
      // Write and step together still advance by one; power-of-two DEPTH wraps for free.
      if (wr_pulse || inc_pulse) begin
        addr_q <= addr_q + AW'(1);
      end
      if (save_pulse) begin
        save_q <= rd_data;
      end
      d_out_q <= show_reg ? save_q : rd_data;
    end
  end

`ifdef MEM_PARITY_EN
  logic par_err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      par_err_q <= 1'b0;
    end else if (save_pulse && (rd_word[DATA_W] != even_parity(MaxDataW'(rd_data)))) begin
      par_err_q <= 1'b1;
    end
  end

  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

  assign d_out    = d_out_q;
  assign addr_out = addr_q;
  assign full     = &written_q;

endmodule

// File: tb/tb_mem_bank_ctrl.sv
// Scoreboard bench for mem_bank_ctrl with DATA_W=8, DEPTH=4, DEB_CYCLES=3.
module tb_mem_bank_ctrl;

  localparam int unsigned DataW = 8;
  localparam int unsigned Depth = 4;
  localparam int unsigned Deb   = 3;

`ifdef MEM_PARITY_EN
  localparam logic ParityOn = 1'b1;
`else
  localparam logic ParityOn = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             write_en = 1'b0;
  logic             save_data = 1'b0;
  logic             addr_inc = 1'b0;
  logic             show_reg = 1'b0;
  logic [DataW-1:0] d_in = '0;
  logic [DataW-1:0] d_out;
  logic [1:0]       addr_out;
  logic             full;
  logic             par_err;

  int tests_run = 0;
  int tests_failed = 0;

  mem_bank_ctrl #(
    .DATA_W     (DataW),
    .DEPTH      (Depth),
    .DEB_CYCLES (Deb)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .write_en  (write_en),
    .save_data (save_data),
    .addr_inc  (addr_inc),
    .show_reg  (show_reg),
    .d_in      (d_in),
    .d_out     (d_out),
    .addr_out  (addr_out),
    .full      (full),
    .par_err   (par_err)
  );

  always #5 clk = ~clk;

  // Reference model of the memory contents and pointer.
  logic [7:0] m_mem [4];
  logic [1:0] m_addr;
  logic [7:0] m_save;
  logic [3:0] m_written;

  typedef struct packed {
    logic [1:0] addr;
    logic [7:0] dout;
    logic       full;
  } exp_t;

  exp_t sb[$];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_mem[i] = 8'h00;
    m_addr    = 2'd0;
    m_save    = 8'h00;
    m_written = 4'b0000;
  endtask

  // Applies one set of simultaneous pulses to the model and records the expected outputs.
  task automatic model_apply(input logic w, input logic s, input logic a, input logic [7:0] data);
    exp_t e;
    if (s) m_save = m_mem[m_addr];
    if (w) begin
      m_mem[m_addr]     = data;
      m_written[m_addr] = 1'b1;
    end
    if (w || a) m_addr = m_addr + 2'd1;
    e.addr = m_addr;
    e.dout = show_reg ? m_save : m_mem[m_addr];
    e.full = (m_written == 4'b1111);
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    model_reset();
  endtask

  // Holds the given buttons long enough for one debounced pulse, then releases and lets it re-arm.
  task automatic press(input logic w, input logic s, input logic a, input logic [7:0] data,
                       input int hold);
    d_in      = data;
    write_en  = w;
    save_data = s;
    addr_inc  = a;
    step(hold);
    write_en  = 1'b0;
    save_data = 1'b0;
    addr_inc  = 1'b0;
    step(5);
    model_apply(w, s, a, data);
  endtask

  task automatic test_reset();
    exp_t e;
    write_en  = 1'b1;
    save_data = 1'b1;
    addr_inc  = 1'b1;
    d_in      = 8'hA5;
    rst       = 1'b0;
    step(2);
    rst = 1'b1;
    model_reset();
    tests_run++;
    if (d_out !== 8'h00) begin
      tests_failed++; $display("FAIL reset_dout: got %0h expected 0", d_out);
    end
    tests_run++;
    if (addr_out !== 2'd0) begin
      tests_failed++; $display("FAIL reset_addr: got %0d expected 0", addr_out);
    end
    tests_run++;
    if (full !== 1'b0) begin
      tests_failed++; $display("FAIL reset_full: got %0b expected 0", full);
    end
    tests_run++;
    if (par_err !== 1'b0) begin
      tests_failed++; $display("FAIL reset_par_err: got %0b expected 0", par_err);
    end
    // Pulse appears DEB+2 edges after release, so the action lands one edge later.
    step(5);
    tests_run++;
    if (addr_out !== 2'd0) begin
      tests_failed++; $display("FAIL reset_pulse_early: got %0d expected 0", addr_out);
    end
    step(1);
    tests_run++;
    if (addr_out !== 2'd1) begin
      tests_failed++; $display("FAIL reset_pulse_time: got %0d expected 1", addr_out);
    end
    step(6);
    write_en  = 1'b0;
    save_data = 1'b0;
    addr_inc  = 1'b0;
    step(5);
    model_apply(1'b1, 1'b1, 1'b1, 8'hA5);
    e = sb.pop_front();
    tests_run++;
    if (addr_out !== e.addr) begin
      tests_failed++; $display("FAIL reset_held_once: got %0d expected %0d", addr_out, e.addr);
    end
    tests_run++;
    if (d_out !== e.dout) begin
      tests_failed++; $display("FAIL reset_held_dout: got %0h expected %0h", d_out, e.dout);
    end
  endtask

  task automatic test_fill();
    exp_t e;
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    do_reset();
    show_reg = 1'b0;
    step(1);
    for (int i = 0; i < 4; i++) begin
      press(1'b1, 1'b0, 1'b0, vals[i], 7);
      e = sb.pop_front();
      tests_run++;
      if (addr_out !== e.addr) begin
        tests_failed++; $display("FAIL fill_addr[%0d]: got %0d expected %0d", i, addr_out, e.addr);
      end
      tests_run++;
      if (full !== e.full) begin
        tests_failed++; $display("FAIL fill_full[%0d]: got %0b expected %0b", i, full, e.full);
      end
      tests_run++;
      if (d_out !== e.dout) begin
        tests_failed++; $display("FAIL fill_dout[%0d]: got %0h expected %0h", i, d_out, e.dout);
      end
    end
  endtask

  task automatic test_bounce();
    exp_t e;
    d_in = 8'h99;
    for (int i = 0; i < 4; i++) begin
      write_en = 1'b1;
      step(2);
      write_en = 1'b0;
      step(1);
    end
    step(6);
    tests_run++;
    if (addr_out !== m_addr) begin
      tests_failed++; $display("FAIL bounce_addr: got %0d expected %0d", addr_out, m_addr);
    end
    tests_run++;
    if (d_out !== m_mem[m_addr]) begin
      tests_failed++; $display("FAIL bounce_dout: got %0h expected %0h", d_out, m_mem[m_addr]);
    end
    press(1'b1, 1'b0, 1'b0, 8'h99, 10);
    e = sb.pop_front();
    tests_run++;
    if (addr_out !== e.addr) begin
      tests_failed++; $display("FAIL held_addr: got %0d expected %0d", addr_out, e.addr);
    end
    tests_run++;
    if (d_out !== e.dout) begin
      tests_failed++; $display("FAIL held_dout: got %0h expected %0h", d_out, e.dout);
    end
    step(8);
    tests_run++;
    if (addr_out !== m_addr) begin
      tests_failed++; $display("FAIL held_single: got %0d expected %0d", addr_out, m_addr);
    end
  endtask

  task automatic test_collisions();
    exp_t e;
    // Write 0x5A and save together at addr 1 over the old 0x22.
    press(1'b1, 1'b1, 1'b0, 8'h5A, 7);
    e = sb.pop_front();
    tests_run++;
    if (addr_out !== e.addr) begin
      tests_failed++; $display("FAIL wr_save_addr: got %0d expected %0d", addr_out, e.addr);
    end
    tests_run++;
    if (d_out !== e.dout) begin
      tests_failed++; $display("FAIL wr_save_dout: got %0h expected %0h", d_out, e.dout);
    end
    for (int i = 0; i < 3; i++) begin
      press(1'b0, 1'b0, 1'b1, 8'h00, 7);
      e = sb.pop_front();
      tests_run++;
      if (addr_out !== e.addr) begin
        tests_failed++; $display("FAIL step_addr[%0d]: got %0d expected %0d", i, addr_out, e.addr);
      end
    end
    // Write and step together at addr 1 must advance by exactly one.
    press(1'b1, 1'b0, 1'b1, 8'h77, 7);
    e = sb.pop_front();
    tests_run++;
    if (addr_out !== e.addr) begin
      tests_failed++; $display("FAIL wr_inc_addr: got %0d expected %0d", addr_out, e.addr);
    end
    for (int i = 0; i < 3; i++) begin
      press(1'b0, 1'b0, 1'b1, 8'h00, 7);
      e = sb.pop_front();
      tests_run++;
      if (d_out !== e.dout) begin
        tests_failed++; $display("FAIL revisit_dout[%0d]: got %0h expected %0h", i, d_out, e.dout);
      end
    end
  endtask

  task automatic test_display();
    show_reg = 1'b1;
    tests_run++;
    if (d_out !== m_mem[m_addr]) begin
      tests_failed++; $display("FAIL show_before: got %0h expected %0h", d_out, m_mem[m_addr]);
    end
    step(1);
    tests_run++;
    if (d_out !== m_save) begin
      tests_failed++; $display("FAIL show_save: got %0h expected %0h", d_out, m_save);
    end
    show_reg = 1'b0;
    step(1);
    tests_run++;
    if (d_out !== m_mem[m_addr]) begin
      tests_failed++; $display("FAIL show_mem: got %0h expected %0h", d_out, m_mem[m_addr]);
    end
  endtask

  task automatic test_parity();
    exp_t e;
    press(1'b0, 1'b0, 1'b1, 8'h00, 7);
    e = sb.pop_front();
    tests_run++;
    if (addr_out !== e.addr) begin
      tests_failed++; $display("FAIL par_addr: got %0d expected %0d", addr_out, e.addr);
    end
`ifdef MEM_PARITY_EN
    force dut.mem_q[2][8] = ~(^m_mem[2]);
`endif
    press(1'b0, 1'b1, 1'b0, 8'h00, 7);
    e = sb.pop_front();
`ifdef MEM_PARITY_EN
    release dut.mem_q[2][8];
`endif
    tests_run++;
    if (par_err !== ParityOn) begin
      tests_failed++; $display("FAIL par_err_set: got %0b expected %0b", par_err, ParityOn);
    end
    press(1'b0, 1'b1, 1'b0, 8'h00, 7);
    e = sb.pop_front();
    tests_run++;
    if (par_err !== ParityOn) begin
      tests_failed++; $display("FAIL par_err_sticky: got %0b expected %0b", par_err, ParityOn);
    end
    do_reset();
    tests_run++;
    if (par_err !== 1'b0) begin
      tests_failed++; $display("FAIL par_err_reset: got %0b expected 0", par_err);
    end
    tests_run++;
    if ({d_out, addr_out, full} !== 11'd0) begin
      tests_failed++; $display("FAIL final_reset: got %0h/%0d/%0b expected 0/0/0",
                               d_out, addr_out, full);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_bounce();
    test_collisions();
    test_display();
    test_parity();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_bank_ctrl.md
# mem_bank_ctrl

Parametrised successor to the single-word lab memory. It is a DEPTH x DATA_W register-file memory driven by raw push-buttons and switches on the FPGA board. It adds:
- an internal address pointer with auto-increment and wrap;
- a manual address-step button;
- per-button debounce/edge pulses generated inside the block;
- a saved-word register whose contents can be shown on the LEDs.

It sits directly under the board top level, fed by the divided board clock from the existing clock generator.

## Interface
Parameters:
- DATA_W, 8, data word width in bits
- DEPTH, 16, number of words (power of two, ≥2); AW = $clog2(DEPTH)
- DEB_CYCLES, 4, consecutive stable-high samples required before a button pulse (≥1)

Ports:
- clk  in  1  single system clock (divided board clock); all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- write_en  in  1  raw button: write d_in at current address
- save_data  in  1  raw button: copy current word into the save register
- addr_inc  in  1  raw button: step address pointer
- show_reg  in  1  level switch: 1 shows the save register, 0 shows mem[addr]
- d_in  in  DATA_W  data switches
- d_out  out  DATA_W  registered display data
- addr_out  out  AW  current address pointer
- full  out  1  high once every address has been written at least once since reset
- par_err  out  1  sticky parity error (see Configuration)

## Operation
- Each raw button goes through btn_pulse:
  - 2-flop synchroniser, then a saturating counter of consecutive high samples.
  - When the counter reaches DEB_CYCLES, a one-cycle pulse is emitted.
  - The button re-arms only after one low synchronised sample; a held button gives exactly one pulse.
- Write pulse:
  - mem[addr] <= d_in.
  - addr <= addr+1, wrapping from DEPTH-1 to 0.
  - Sets written[addr].
- addr_inc pulse: addr <= addr+1, same wrap rule.
- Save pulse: save_reg <= mem[addr], using the value before any write in the same cycle.
- Simultaneous write and addr_inc in the same cycle: addr advances by exactly 1, not 2.
- Simultaneous write and save in the same cycle: save captures the old word; the write still happens.
- full = AND of the DEPTH written bits; it stays high until reset.
- d_out <= show_reg ? save_reg : mem[addr], registered every cycle.

## Timing
- Reset (rst=0 at an edge) takes effect at that edge. It clears:
  - all mem words to 0, save_reg, addr, written bits;
  - d_out, addr_out, full, par_err to 0;
  - all btn_pulse synchronisers and counters.
- Reset has priority over all pulses. A button held through reset release produces one pulse, DEB_CYCLES+2 edges after release, as if newly pressed.
- Raw button high before edge k: pulse is high in the cycle after edge k+1+DEB_CYCLES, for exactly one cycle.
- Action for a pulse (write/step/save) takes effect at the next edge, e.
- d_out reflects the new state at edge e+1 (one cycle of display latency).
- show_reg is not debounced: a change at edge t appears on d_out at edge t+1.
- addr_out is a direct copy of the addr register, valid at edge e.

## Configuration
- MEM_PARITY_EN defined:
  - Each word stores DATA_W+1 bits; the extra bit is even parity of d_in.
  - On a save pulse, the parity of the read word is checked. A mismatch sets par_err, which stays high until reset.
  - No mismatch can occur without a fault-injection path, so the bench forces the stored parity bit.
- MEM_PARITY_EN undefined: no parity storage; par_err is tied to 0.

## Structure
- Shared package mem_pkg holds:
  - default constants for DATA_W, DEPTH, DEB_CYCLES;
  - a function giving even parity over DATA_W bits.
- One sub-module, btn_pulse (parameter DEB_CYCLES; ports clk, rst, i_btn, o_pulse), is instantiated three times.
- Memory array, pointer, save register and output mux live in mem_bank_ctrl.

## Test plan
All scenarios use DATA_W=8, DEPTH=4, DEB_CYCLES=3.
- Reset: drive rst=0 for 2 cycles with buttons high → d_out=0, addr_out=0, full=0, par_err=0; one write pulse occurs 5 edges after release.
- Fill: write 0x11, 0x22, 0x33, 0x44 (release between presses) → addr_out wraps 3→0; full=1 after the 4th write; d_out=0x11 one edge later.
- Bounce: toggle write_en high for 2 cycles, low for 1, repeated → no write; held high 10 cycles → exactly one write.
- Collisions:
  - write+addr_inc pulse in the same cycle at addr 1 → addr_out=2, mem[1]=d_in.
  - write(0x5A)+save in the same cycle over old 0x22 → save_reg=0x22; show_reg=1 gives d_out=0x22.
- Display: show_reg toggled 0→1 → d_out switches from mem[addr] to save_reg on the next edge.
- MEM_PARITY_EN: force the stored parity bit of mem[2], then save at addr 2 → par_err=1, still 1 after further saves, 0 only after reset.
